lu_bit_sequencer: RTL and testbench

Bit-serial operand sequencer and result collector for the 1-bit OR/NOR logic unit with its 2:1 select mux. It accepts two WIDTH-bit operands and an operation code, drives the unit's x, y and s inputs one bit per clock, LSB first, and samples the unit's z output back each cycle. From those samples it assembles a WIDTH-bit result and a count of ones, and reports completion through a start/busy/done handshake.

---
 rtl/lu_bit_sequencer.sv | 113 +++++++++++
 tb/tb_lu_bit_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lu_bit_sequencer.sv
// Bit-serial operand sequencer for the 1-bit OR/NOR logic unit: streams operands
// LSB first on x/y/s, samples z back each cycle and assembles result and ones count.
module lu_bit_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             x,
  output logic             y,
  output logic             s,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    ones
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    ones_q, ones_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      result_q <= result_d;
      ones_q   <= ones_d;
    end
  end

  // Next state, datapath update and unit drive
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    result_d = result_q;
    ones_d   = ones_q;
    x        = 1'b0;
    y        = 1'b0;
    s        = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d    = opa;
          opb_d    = opb;
          op_d     = op;
          result_d = '0;
          ones_d   = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy            = 1'b1;
        x               = opa_q[idx_q];
        y               = opb_q[idx_q];
        s               = op_q;
        result_d[idx_q] = z;
        ones_d          = ones_q + CW'(z);
        if (idx_q == IW'(WIDTH - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;
  assign ones   = ones_q;

endmodule

// File: tb/tb_lu_bit_sequencer.sv
// Directed bench for lu_bit_sequencer; a behavioural OR/NOR mux closes the z loop.
module tb_lu_bit_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       x, y, s, z;
  logic       busy, done;
  logic [3:0] result;
  logic [2:0] ones;

  int checks = 0;
  int errors = 0;

  lu_bit_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .x(x), .y(y), .s(s), .z(z), .busy(busy), .done(done),
    .result(result), .ones(ones)
  );

  // The logic unit being sequenced
  assign z = s ? (x | y) : ~(x | y);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the done pulse; a timeout is itself a failed check
  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int done_cnt;
    int last;
    int npulse;
    logic prev_busy;
    logic [1:0] exp_x [4];
    logic [1:0] exp_y [4];

    // Reset with no clock edge yet
    reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    #2;
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ones", 32'(ones), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // OR 1010 | 0101
    opa = 4'b1010; opb = 4'b0101; op = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_x = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_y = '{2'd1, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("or_x%0d", i), 32'(x), 32'(exp_x[i][0]));
      chk($sformatf("or_y%0d", i), 32'(y), 32'(exp_y[i][0]));
      chk($sformatf("or_s%0d", i), 32'(s), 1);
      chk($sformatf("or_busy%0d", i), 32'(busy), 1);
      chk($sformatf("or_nodone%0d", i), 32'(done), 0);
      tick();
    end
    chk("or_done", 32'(done), 1);
    chk("or_done_busy", 32'(busy), 1);
    chk("or_done_x", 32'(x), 0);
    chk("or_result", 32'(result), 32'hF);
    chk("or_ones", 32'(ones), 4);
    tick();
    chk("or_idle_done", 32'(done), 0);
    chk("or_idle_busy", 32'(busy), 0);
    chk("or_hold_result", 32'(result), 32'hF);
    chk("or_hold_ones", 32'(ones), 4);

    // NOR 0011 / 0101 -> 1000
    opa = 4'b0011; opb = 4'b0101; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nor_clear_result", 32'(result), 0);
    chk("nor_clear_ones", 32'(ones), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nor_s%0d", i), 32'(s), 0);
      tick();
    end
    chk("nor_done", 32'(done), 1);
    chk("nor_result", 32'(result), 32'h8);
    chk("nor_ones", 32'(ones), 1);
    tick();

    // start held; operand change mid-run is ignored
    opa = 4'b1100; opb = 4'b0001; op = 1'b1; start = 1'b1;
    done_cnt = 0;
    tick();
    chk("hold_x0", 32'(x), 0);
    chk("hold_y0", 32'(y), 1);
    tick();
    opa = 4'b1111;
    chk("hold_x1", 32'(x), 0);
    tick();
    chk("hold_x2", 32'(x), 1);
    tick();
    tick();
    if (done) done_cnt++;
    chk("hold_result", 32'(result), 32'hD);
    chk("hold_ones", 32'(ones), 3);
    tick();
    if (done) done_cnt++;
    chk("hold_idle_busy", 32'(busy), 0);
    tick();
    if (done) done_cnt++;
    chk("hold_one_done", 32'(done_cnt), 1);
    chk("hold_reaccept_busy", 32'(busy), 1);
    chk("hold_reaccept_clear", 32'(result), 0);
    start = 1'b0;
    wait_done("hold2");
    chk("hold2_result", 32'(result), 32'hF);
    tick();

    // Reset in RUN cycle 2
    opa = 4'b1010; opb = 4'b0101; op = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("abort_partial", 32'(result), 32'h3);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_ones", 32'(ones), 0);
    chk("abort_x", 32'(x), 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 0);
    reset = 1'b0;
    tick();
    opa = 4'b0011; opb = 4'b0101; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("after_abort");
    chk("after_abort_result", 32'(result), 32'h8);
    chk("after_abort_ones", 32'(ones), 1);
    tick();

    // Back-to-back with start held continuously
    opa = 4'b1010; opb = 4'b0101; op = 1'b1; start = 1'b1;
    last = -1; npulse = 0; prev_busy = busy;
    for (int cyc = 0; cyc < 26; cyc++) begin
      tick();
      if (busy && !prev_busy) chk($sformatf("b2b_clear%0d", cyc), 32'(result), 0);
      if (done) begin
        if (last >= 0) chk($sformatf("b2b_gap%0d", cyc), 32'(cyc - last), 6);
        chk($sformatf("b2b_result%0d", cyc), 32'(result), 32'hF);
        last = cyc;
        npulse++;
      end
      prev_busy = busy;
    end
    chk("b2b_pulses", 32'(npulse), 4);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
